// File: rtl/pipe_ctrl_pkg.sv
// Shared decode constants, control bundle types and the instruction decoder.
// Build macro CTRL_EXT_OPS_EN adds ADDI and BNE to the decoder.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic [2:0] alucontrol;
  } ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memwrite;
  } memCtrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wbCtrl_t;

  typedef struct packed {
    ctrl_t ctrl;
    logic  jump;
    logic  branch;
    logic  branchNe;
    logic  illegal;
    logic  isMul;
  } decode_t;

  function automatic decode_t decodeInstr(input logic [5:0] opcode, input logic [5:0] funct);
    decode_t d;
    d = '0;
    case (opcode)
      OP_RTYPE: begin
        d.ctrl.regwrite = 1'b1;
        d.ctrl.regdst   = 1'b1;
        case (funct)
          FN_ADD:  d.ctrl.alucontrol = ALU_ADD;
          FN_SUB:  d.ctrl.alucontrol = ALU_SUB;
          FN_AND:  d.ctrl.alucontrol = ALU_AND;
          FN_OR:   d.ctrl.alucontrol = ALU_OR;
          FN_SLT:  d.ctrl.alucontrol = ALU_SLT;
          FN_MUL: begin
            d.ctrl.alucontrol = ALU_MUL;
            d.isMul           = 1'b1;
          end
          default: d.illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        d.ctrl.regwrite   = 1'b1;
        d.ctrl.memtoreg   = 1'b1;
        d.ctrl.alusrc     = 1'b1;
        d.ctrl.alucontrol = ALU_ADD;
      end
      OP_SW: begin
        d.ctrl.memwrite   = 1'b1;
        d.ctrl.alusrc     = 1'b1;
        d.ctrl.alucontrol = ALU_ADD;
      end
      OP_BEQ: begin
        d.branch          = 1'b1;
        d.ctrl.alucontrol = ALU_SUB;
      end
      OP_J: d.jump = 1'b1;
`ifdef CTRL_EXT_OPS_EN
      OP_ADDI: begin
        d.ctrl.regwrite   = 1'b1;
        d.ctrl.alusrc     = 1'b1;
        d.ctrl.alucontrol = ALU_ADD;
      end
      OP_BNE: begin
        d.branch          = 1'b1;
        d.branchNe        = 1'b1;
        d.ctrl.alucontrol = ALU_SUB;
      end
`endif
      default: d.illegal = 1'b1;
    endcase
    // An illegal word must enter E as a bubble.
    if (d.illegal) begin
      d.ctrl  = '0;
      d.isMul = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode inputs, hazard controls and per-stage control outputs of the pipeline control unit.
interface pipe_ctrl_if #(parameter int ALUCTRL_W = 3);
  logic [5:0]           opcode_d;
  logic [5:0]           funct_d;
  logic                 stall_d;
  logic                 flush_e;
  logic                 jump_d;
  logic                 branch_d;
  logic                 branch_ne_d;
  logic                 illegal_d;
  logic                 regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e;
  logic [ALUCTRL_W-1:0] alucontrol_e;
  logic                 regwrite_m, memtoreg_m, memwrite_m;
  logic                 regwrite_w, memtoreg_w;
  logic                 stall_mult;

  modport slave (
    input  opcode_d, funct_d, stall_d, flush_e,
    output jump_d, branch_d, branch_ne_d, illegal_d,
           regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e, alucontrol_e,
           regwrite_m, memtoreg_m, memwrite_m, regwrite_w, memtoreg_w, stall_mult
  );

  modport master (
    output opcode_d, funct_d, stall_d, flush_e,
    input  jump_d, branch_d, branch_ne_d, illegal_d,
           regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e, alucontrol_e,
           regwrite_m, memtoreg_m, memwrite_m, regwrite_w, memtoreg_w, stall_mult
  );
endinterface

// File: rtl/mult_busy_timer.sv
// Counts the extra Execute cycles a MUL occupies; busy while the count is nonzero.
module mult_busy_timer #(
  parameter int MULT_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);
  localparam int CW = $clog2(MULT_LAT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MULT_LAT - 1);

  logic [CW-1:0] count;

  // Loads only from zero, so the count can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              count <= '0;
    else if (count != '0)    count <= count - 1'b1;
    else if (load)           count <= LOAD_VAL;
  end

  assign busy = (count != '0);
endmodule

// File: rtl/pipe_ctrl_unit.sv
// MIPS pipeline control: D-stage decode, ID/EX, EX/MEM, MEM/WB control registers and MUL stall.
// Build macro CTRL_EXT_OPS_EN enables ADDI/BNE decode (see pipe_ctrl_pkg).
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int MULT_LAT  = 4
) (
  input logic       clk,
  input logic       rst_n,
  pipe_ctrl_if.slave bus
);
  decode_t  dec;
  ctrl_t    eReg;
  memCtrl_t mReg;
  wbCtrl_t  wReg;
  logic     busy;
  logic     bubbleE;

  always_comb dec = decodeInstr(bus.opcode_d, bus.funct_d);

  assign bubbleE = bus.flush_e | bus.stall_d;

  // Counter starts on the same edge the MUL lands in E, so stall is visible in its first E cycle.
  mult_busy_timer #(.MULT_LAT(MULT_LAT)) uTimer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (!busy && !bubbleE && dec.isMul),
    .busy  (busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eReg <= '0;
      mReg <= '0;
      wReg <= '0;
    end else begin
      wReg <= '{regwrite: mReg.regwrite, memtoreg: mReg.memtoreg};
      if (busy) begin
        mReg <= '0;
      end else begin
        mReg <= '{regwrite: eReg.regwrite, memtoreg: eReg.memtoreg, memwrite: eReg.memwrite};
        eReg <= bubbleE ? '0 : dec.ctrl;
      end
    end
  end

  assign bus.jump_d       = dec.jump;
  assign bus.branch_d     = dec.branch;
  assign bus.branch_ne_d  = dec.branchNe;
  assign bus.illegal_d    = dec.illegal;
  assign bus.regwrite_e   = eReg.regwrite;
  assign bus.memtoreg_e   = eReg.memtoreg;
  assign bus.memwrite_e   = eReg.memwrite;
  assign bus.alusrc_e     = eReg.alusrc;
  assign bus.regdst_e     = eReg.regdst;
  assign bus.alucontrol_e = ALUCTRL_W'(eReg.alucontrol);
  assign bus.regwrite_m   = mReg.regwrite;
  assign bus.memtoreg_m   = mReg.memtoreg;
  assign bus.memwrite_m   = mReg.memwrite;
  assign bus.regwrite_w   = wReg.regwrite;
  assign bus.memtoreg_w   = wReg.memtoreg;
  assign bus.stall_mult   = busy;
endmodule
